// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
// Holds the packet-lock FSM encoding and the cyclic channel-index helper.
package rr_mux_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Cyclic index: (base + off) mod n, used for both scanning and pointer advance.
  function automatic int rot_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational rotate-priority arbiter: the first requester found scanning
// cyclically upward from ptr wins.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int CHANNELS = 4
) (
  input  logic [CHANNELS-1:0]         req,
  input  logic [$clog2(CHANNELS)-1:0] ptr,
  output logic                        gnt_valid,
  output logic [$clog2(CHANNELS)-1:0] gnt_idx
);

  localparam int CHW = $clog2(CHANNELS);

  logic [CHW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester to ptr is the last write.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = CHW'(rot_idx(int'(ptr), i, CHANNELS));
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream merger with round-robin arbitration, optional
// packet lock, and a single-entry registered output stage.
module rr_stream_mux
  import rr_mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int PKT_MODE = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CHANNELS-1:0]              in_valid,
  output logic [CHANNELS-1:0]              in_ready,
  input  logic [CHANNELS-1:0][WIDTH-1:0]   in_data,
  input  logic [CHANNELS-1:0]              in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic                             out_last,
  output logic [$clog2(CHANNELS)-1:0]      out_chan
);

  localparam int CHW = $clog2(CHANNELS);

  state_e           state_q;
  logic [CHW-1:0]   lock_q;
  logic [CHW-1:0]   ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [CHW-1:0]   out_chan_q, out_chan_d;

  logic             arb_valid;
  logic [CHW-1:0]   arb_idx;
  logic             gnt_valid;
  logic [CHW-1:0]   gnt_idx;
  logic             space;
  logic             xfer;
  logic             beat_last;

  rr_arbiter #(
    .CHANNELS(CHANNELS)
  ) u_arb (
    .req      (in_valid),
    .ptr      (ptr_q),
    .gnt_valid(arb_valid),
    .gnt_idx  (arb_idx)
  );

  // While locked, only the owning channel may be granted, even if it goes idle.
  always_comb begin
    if (PKT_MODE != 0 && state_q == LOCKED) begin
      gnt_valid = in_valid[lock_q];
      gnt_idx   = lock_q;
    end else begin
      gnt_valid = arb_valid;
      gnt_idx   = arb_idx;
    end
  end

  assign space     = !out_valid_q || out_ready;
  assign xfer      = gnt_valid && space && rst_n;
  assign beat_last = (PKT_MODE == 0) ? 1'b1 : in_last[gnt_idx];

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[gnt_idx];
      out_last_d  = beat_last;
      out_chan_d  = gnt_idx;
      if (beat_last) begin
        ptr_d = CHW'(rot_idx(int'(gnt_idx), 1, CHANNELS));
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      lock_q  <= '0;
    end else if (PKT_MODE != 0 && xfer) begin
      case (state_q)
        ARB: begin
          if (!beat_last) begin
            state_q <= LOCKED;
            lock_q  <= gnt_idx;
          end
        end
        LOCKED: begin
          if (beat_last) begin
            state_q <= ARB;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: beat-mode 4-channel, packet-mode 4-channel
// and beat-mode 3-channel instances driven from per-cycle vector tables.
module tb_rr_stream_mux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  a_in_valid, a_in_ready, a_in_last;
  logic [15:0] a_in_data;
  logic        a_out_valid, a_out_ready, a_out_last;
  logic [3:0]  a_out_data;
  logic [1:0]  a_out_chan;

  logic [3:0]  b_in_valid, b_in_ready, b_in_last;
  logic [15:0] b_in_data;
  logic        b_out_valid, b_out_ready, b_out_last;
  logic [3:0]  b_out_data;
  logic [1:0]  b_out_chan;

  logic [2:0]  c_in_valid, c_in_ready, c_in_last;
  logic [11:0] c_in_data;
  logic        c_out_valid, c_out_ready, c_out_last;
  logic [3:0]  c_out_data;
  logic [1:0]  c_out_chan;

  rr_stream_mux #(.WIDTH(4), .CHANNELS(4), .PKT_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_last(a_in_last), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last),
    .out_chan(a_out_chan));

  rr_stream_mux #(.WIDTH(4), .CHANNELS(4), .PKT_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .out_chan(b_out_chan));

  rr_stream_mux #(.WIDTH(4), .CHANNELS(3), .PKT_MODE(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .out_last(c_out_last),
    .out_chan(c_out_chan));

  typedef struct packed {
    logic [3:0]  valid;
    logic [15:0] data;
    logic [3:0]  last;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [3:0]  e_data;
    logic [1:0]  e_chan;
    logic        e_last;
  } vec_t;

  int errors = 0;
  int checks = 0;

  vec_t va[7];
  vec_t vb[18];
  vec_t vc[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sample(input int sel, output logic [3:0] rdy, output logic ov,
                        output logic [3:0] od, output logic [1:0] oc, output logic ol);
    case (sel)
      0: begin rdy = a_in_ready; ov = a_out_valid; od = a_out_data; oc = a_out_chan; ol = a_out_last; end
      1: begin rdy = b_in_ready; ov = b_out_valid; od = b_out_data; oc = b_out_chan; ol = b_out_last; end
      default: begin rdy = {1'b0, c_in_ready}; ov = c_out_valid; od = c_out_data; oc = c_out_chan; ol = c_out_last; end
    endcase
  endtask

  task automatic check_outs(input string tag, input int sel, input vec_t v);
    logic [3:0] rdy, od;
    logic       ov, ol;
    logic [1:0] oc;
    sample(sel, rdy, ov, od, oc, ol);
    chk({tag, ".in_ready"}, 32'(rdy), 32'(v.e_rdy));
    chk({tag, ".out_valid"}, 32'(ov), 32'(v.e_ov));
    if (v.e_ov) begin
      chk({tag, ".out_data"}, 32'(od), 32'(v.e_data));
      chk({tag, ".out_chan"}, 32'(oc), 32'(v.e_chan));
      chk({tag, ".out_last"}, 32'(ol), 32'(v.e_last));
    end
  endtask

  task automatic apply(input int sel, input vec_t v, input string tag);
    @(negedge clk);
    case (sel)
      0: begin a_in_valid = v.valid; a_in_data = v.data; a_in_last = v.last; a_out_ready = v.ordy; end
      1: begin b_in_valid = v.valid; b_in_data = v.data; b_in_last = v.last; b_out_ready = v.ordy; end
      default: begin
        c_in_valid = v.valid[2:0]; c_in_data = v.data[11:0];
        c_in_last = v.last[2:0]; c_out_ready = v.ordy;
      end
    endcase
    #1;
    check_outs(tag, sel, v);
  endtask

  initial begin
    vec_t rv;
    // Beat mode, 4 channels: {valid, data, last, ordy, e_rdy, e_ov, e_data, e_chan, e_last}
    va[0] = '{4'hF, 16'hDCBA, 4'h0, 1'b1, 4'h1, 1'b0, 4'h0, 2'd0, 1'b0};
    va[1] = '{4'hF, 16'hDCBA, 4'h0, 1'b1, 4'h2, 1'b1, 4'hA, 2'd0, 1'b1};
    va[2] = '{4'hF, 16'hDCBA, 4'h0, 1'b1, 4'h4, 1'b1, 4'hB, 2'd1, 1'b1};
    va[3] = '{4'hF, 16'hDCBA, 4'h0, 1'b1, 4'h8, 1'b1, 4'hC, 2'd2, 1'b1};
    va[4] = '{4'hF, 16'hDCBA, 4'h0, 1'b1, 4'h1, 1'b1, 4'hD, 2'd3, 1'b1};
    va[5] = '{4'h0, 16'hDCBA, 4'h0, 1'b1, 4'h0, 1'b1, 4'hA, 2'd0, 1'b1};
    va[6] = '{4'h0, 16'hDCBA, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0};

    // Packet mode: ch1 3-beat packet with a 2-cycle gap, ch2 waiting, then backpressure on ch3
    vb[0]  = '{4'h6, 16'h0910, 4'h4, 1'b1, 4'h2, 1'b0, 4'h0, 2'd0, 1'b0};
    vb[1]  = '{4'h4, 16'h0910, 4'h4, 1'b1, 4'h0, 1'b1, 4'h1, 2'd1, 1'b0};
    vb[2]  = '{4'h4, 16'h0910, 4'h4, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0};
    vb[3]  = '{4'h6, 16'h0920, 4'h4, 1'b1, 4'h2, 1'b0, 4'h0, 2'd0, 1'b0};
    vb[4]  = '{4'h6, 16'h0930, 4'h6, 1'b1, 4'h2, 1'b1, 4'h2, 2'd1, 1'b0};
    vb[5]  = '{4'h4, 16'h0900, 4'h4, 1'b1, 4'h4, 1'b1, 4'h3, 2'd1, 1'b1};
    vb[6]  = '{4'h0, 16'h0000, 4'h0, 1'b1, 4'h0, 1'b1, 4'h9, 2'd2, 1'b1};
    vb[7]  = '{4'h0, 16'h0000, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0};
    vb[8]  = '{4'h8, 16'h5000, 4'h8, 1'b0, 4'h8, 1'b0, 4'h0, 2'd0, 1'b0};
    for (int i = 9; i < 14; i++)
      vb[i] = '{4'h8, 16'h6000, 4'h8, 1'b0, 4'h0, 1'b1, 4'h5, 2'd3, 1'b1};
    vb[14] = '{4'h8, 16'h6000, 4'h8, 1'b1, 4'h8, 1'b1, 4'h5, 2'd3, 1'b1};
    vb[15] = '{4'h0, 16'h0000, 4'h0, 1'b1, 4'h0, 1'b1, 4'h6, 2'd3, 1'b1};
    vb[16] = '{4'h0, 16'h0000, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0};
    vb[17] = '{4'h4, 16'h0700, 4'h0, 1'b1, 4'h4, 1'b0, 4'h0, 2'd0, 1'b0};

    // Three channels, beat mode: ch1 first moves ptr to 2, then ch0/ch2 alternate across the wrap
    vc[0] = '{4'h2, 16'h0E71, 4'h0, 1'b1, 4'h2, 1'b0, 4'h0, 2'd0, 1'b0};
    vc[1] = '{4'h5, 16'h0E71, 4'h0, 1'b1, 4'h4, 1'b1, 4'h7, 2'd1, 1'b1};
    vc[2] = '{4'h5, 16'h0E71, 4'h0, 1'b1, 4'h1, 1'b1, 4'hE, 2'd2, 1'b1};
    vc[3] = '{4'h5, 16'h0E71, 4'h0, 1'b1, 4'h4, 1'b1, 4'h1, 2'd0, 1'b1};
    vc[4] = '{4'h5, 16'h0E71, 4'h0, 1'b1, 4'h1, 1'b1, 4'hE, 2'd2, 1'b1};
    vc[5] = '{4'h0, 16'h0E71, 4'h0, 1'b1, 4'h0, 1'b1, 4'h1, 2'd0, 1'b1};
    vc[6] = '{4'h0, 16'h0E71, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0};

    // Reset with every channel requesting
    a_in_valid = 4'hF; a_in_data = 16'hDCBA; a_in_last = 4'h0; a_out_ready = 1'b1;
    b_in_valid = 4'hF; b_in_data = 16'h1234; b_in_last = 4'h0; b_out_ready = 1'b1;
    c_in_valid = 3'h7; c_in_data = 12'h123;  c_in_last = 3'h0; c_out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset.a.in_ready", 32'(a_in_ready), 32'h0);
    chk("reset.a.out_valid", 32'(a_out_valid), 32'h0);
    chk("reset.a.out_data", 32'(a_out_data), 32'h0);
    chk("reset.b.in_ready", 32'(b_in_ready), 32'h0);
    chk("reset.c.in_ready", 32'(c_in_ready), 32'h0);
    a_in_valid = 4'h0; b_in_valid = 4'h0; c_in_valid = 3'h0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) apply(0, va[i], $sformatf("beat[%0d]", i));
    for (int i = 0; i < 7; i++) apply(2, vc[i], $sformatf("ch3[%0d]", i));
    for (int i = 0; i < 18; i++) apply(1, vb[i], $sformatf("pkt[%0d]", i));

    // Reset while dut_b is locked on ch2 with a held beat
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rv = '{4'h4, 16'h0700, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0};
    check_outs("midrst", 1, rv);
    chk("midrst.out_data", 32'(b_out_data), 32'h0);
    chk("midrst.out_chan", 32'(b_out_chan), 32'h0);
    chk("midrst.out_last", 32'(b_out_last), 32'h0);
    b_in_valid = 4'h5; b_in_data = 16'h0804; b_in_last = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst.release.in_ready", 32'(b_in_ready), 32'h1);
    apply(1, '{4'h0, 16'h0000, 4'h0, 1'b1, 4'h0, 1'b1, 4'h4, 2'd0, 1'b0}, "midrst.after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
